// File: rtl/me_best_mv_if.sv
// me_best_mv_if: control, SAD stream and result bundle for me_best_mv.
// Master drives start/sad; slave returns busy/done and the winning vector.
interface me_best_mv_if #(
  parameter int POS_W = 6
);
  logic             start;
  logic             sad_valid;
  logic [15:0]      sad;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] mv_x;
  logic [POS_W-1:0] mv_y;
  logic [15:0]      min_sad;

  modport master (
    output start, sad_valid, sad,
    input  busy, done, mv_x, mv_y, min_sad
  );

  modport slave (
    input  start, sad_valid, sad,
    output busy, done, mv_x, mv_y, min_sad
  );
endinterface

// File: rtl/me_best_mv.sv
// me_best_mv: tracks the minimum SAD over a raster-ordered search window.
// Define ME_ZERO_BIAS_EN to credit the (0,0) candidate by ZERO_BIAS.
module me_best_mv #(
  parameter int          MACRO_DIM  = 16,
  parameter int          SEARCH_DIM = 48,
  parameter logic [15:0] ZERO_BIAS  = 16'd64,
  localparam int         N          = SEARCH_DIM - MACRO_DIM + 1,
  localparam int         R          = (N - 1) / 2,
  localparam int         POS_W      = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  me_best_mv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  localparam logic [POS_W-1:0] LAST = POS_W'(N - 1);
  localparam logic [POS_W-1:0] CTR  = POS_W'(R);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [POS_W-1:0] cand_x;
  logic [POS_W-1:0] cand_y;
  logic [POS_W-1:0] best_x;
  logic [POS_W-1:0] best_y;
  logic [15:0]      best_sad;
  logic [POS_W-1:0] mv_x;
  logic [POS_W-1:0] mv_y;
  logic [15:0]      min_sad;
  logic [15:0]      key;
  logic             accept;
  logic             x_wrap;
  logic             last;
  logic             upd;

`ifdef ME_ZERO_BIAS_EN
  always_comb begin
    key = bus.sad;
    if (cand_x == CTR && cand_y == CTR)
      key = (bus.sad > ZERO_BIAS) ? bus.sad - ZERO_BIAS : '0;
  end
`else
  logic unused_bias;
  assign unused_bias = ^ZERO_BIAS;
  always_comb begin
    key = bus.sad;
  end
`endif

  assign accept = (state == SEARCH) && bus.sad_valid;
  assign x_wrap = (cand_x == LAST);
  assign last   = x_wrap && (cand_y == LAST);
  // best_sad holds the raw SAD, so a biased key is compared against it
  assign upd    = (key < best_sad);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SEARCH;
      SEARCH:  if (accept && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_x   <= '0;
      cand_y   <= '0;
      best_x   <= '0;
      best_y   <= '0;
      best_sad <= 16'hFFFF;
      mv_x     <= '0;
      mv_y     <= '0;
      min_sad  <= '0;
    end else if (state == IDLE && bus.start) begin
      cand_x   <= '0;
      cand_y   <= '0;
      best_x   <= '0;
      best_y   <= '0;
      best_sad <= 16'hFFFF;
    end else if (accept) begin
      if (upd) begin
        best_sad <= bus.sad;
        best_x   <= cand_x;
        best_y   <= cand_y;
      end
      cand_x <= x_wrap ? '0 : cand_x + ONE;
      if (x_wrap) cand_y <= cand_y + ONE;
      // results land on the edge entering DONE, including the last candidate
      if (last) begin
        mv_x    <= (upd ? cand_x : best_x) - CTR;
        mv_y    <= (upd ? cand_y : best_y) - CTR;
        min_sad <= upd ? bus.sad : best_sad;
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.mv_x    = mv_x;
  assign bus.mv_y    = mv_y;
  assign bus.min_sad = min_sad;

endmodule

// File: tb/tb_me_best_mv.sv
// tb_me_best_mv: scoreboard bench for me_best_mv, default 16/48 geometry.
// Expected results come from a plain argmin model over the candidate array.
module tb_me_best_mv;
  localparam int N  = 33;
  localparam int R  = 16;
  localparam int NC = N * N;

  typedef struct {
    int mx;
    int my;
    int ms;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_best_mv_if #(.POS_W(6)) bus ();

  me_best_mv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t        exp_q[$];
  res_t        mon_e;
  res_t        held;
  res_t        none;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_smp = -1;
  logic        prev_done = 1'b0;
  logic [15:0] cand[NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  function automatic res_t model();
    res_t r;
    int bs = 'hFFFF;
    int bi = 0;
    int k;
    for (int i = 0; i < NC; i++) begin
      k = int'(cand[i]);
`ifdef ME_ZERO_BIAS_EN
      if (i == R * N + R) k = (k > 64) ? k - 64 : 0;
`endif
      if (k < bs) begin
        bs = int'(cand[i]);
        bi = i;
      end
    end
    r.mx = (bi % N) - R;
    r.my = (bi / N) - R;
    r.ms = bs;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      chk("done_one_cycle", int'(prev_done), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual 1 required 0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("mv_x", int'($signed(bus.mv_x)), mon_e.mx);
        chk("mv_y", int'($signed(bus.mv_y)), mon_e.my);
        chk("min_sad", int'(bus.min_sad), mon_e.ms);
        chk("done_latency", cyc, last_smp);
      end
    end
    prev_done <= bus.done;
  end

  task automatic fill(input int v);
    for (int i = 0; i < NC; i++) cand[i] = 16'(v);
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < NC; i++) cand[i] = 16'($urandom_range(hi, lo));
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_rise", int'(bus.busy), 1);
  endtask

  task automatic run_search(input bit stall, input bit hold_chk,
                            input res_t prev);
    bit bsy_ok = 1'b1;
    exp_q.push_back(model());
    do_start();
    for (int i = 0; i < NC; i++) begin
      if (stall) begin
        bus.sad_valid = 1'b0;
        bus.sad       = 16'($urandom);
        bus.start     = (i == 500);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (!bus.busy) bsy_ok = 1'b0;
      end
      bus.sad_valid = 1'b1;
      bus.sad       = cand[i];
      if (i == NC - 1) last_smp = cyc + 1;
      @(posedge clk);
      #1;
      if (!bus.busy) bsy_ok = 1'b0;
      if (hold_chk && i == 600) begin
        chk("hold_mv_x", int'($signed(bus.mv_x)), prev.mx);
        chk("hold_mv_y", int'($signed(bus.mv_y)), prev.my);
        chk("hold_min_sad", int'(bus.min_sad), prev.ms);
      end
    end
    bus.sad_valid = 1'b0;
    bus.sad       = 16'($urandom);
    if (stall) chk("busy_held", int'(bsy_ok), 1);
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("done_seen", exp_q.size(), 0);
    exp_q.delete();
    chk("busy_fall", int'(bus.busy), 0);
  endtask

  task automatic abort_search(input int n);
    do_start();
    for (int i = 0; i < n; i++) begin
      bus.sad_valid = 1'b1;
      bus.sad       = 16'($urandom);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_mv_x", int'(bus.mv_x), 0);
    chk("rst_mv_y", int'(bus.mv_y), 0);
    chk("rst_min_sad", int'(bus.min_sad), 0);
    bus.sad_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    none = '{0, 0, 0};
    bus.start     = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_mv_x", int'(bus.mv_x), 0);
    chk("reset_mv_y", int'(bus.mv_y), 0);
    chk("reset_min_sad", int'(bus.min_sad), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill(100);
    run_search(1'b0, 1'b0, none);

    fill(500);
    cand[5 * N + 20] = 16'd3;
    run_search(1'b0, 1'b0, none);

    fill(500);
    cand[NC - 1] = 16'd3;
    run_search(1'b0, 1'b0, none);

    fill(200);
    run_search(1'b1, 1'b0, none);

    abort_search(400);
    fill_rand(0, 40);
    run_search(1'b0, 1'b0, none);

    fill(1000);
    cand[R * N + R]             = 16'd150;
    cand[(R + 2) * N + (R + 3)] = 16'd120;
    run_search(1'b0, 1'b0, none);

    fill(16'hFFFF);
    run_search(1'b0, 1'b0, none);

    bus.sad_valid = 1'b1;
    bus.sad       = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    bus.sad_valid = 1'b0;
    fill_rand(100, 3000);
    cand[$urandom_range(NC - 1)] = 16'd7;
    held = model();
    run_search(1'b0, 1'b0, none);
    fill_rand(100, 3000);
    cand[$urandom_range(NC - 1)] = 16'd9;
    run_search(1'b0, 1'b1, held);

    fill_rand(0, 8);
    run_search(1'b0, 1'b0, none);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
